branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit. Carries the fetch-time prediction (`predict_taken`, `predict1_taken`, `predict3_taken`, `is_loop`, `predict_target_pc`) from IF through DEC to EX alongside the instruction. In EX it evaluates the conditional-branch compare and flags a misprediction with the correct redirect PC. It also produces the update/training signals consumed by `branch_predict` and keeps saturating performance counters.

## Interface
Parameters
- `CNT_WIDTH`, default 32: width of the performance counters.

Ports
- `cpu_clk`  in  1  core clock. One clock; all state on the rising edge.
- `cpu_rstn`  in  1  asynchronous, active-low reset.
- `predict_taken`, `predict1_taken`, `predict3_taken`, `is_loop`  in  1 each  prediction for the instruction currently in IF.
- `predict_target_pc`  in  `ADDR_WIDTH`  predicted target for the IF instruction.
- `if_valid`  in  1  IF holds a valid instruction.
- `dec_en`  in  1  IF→DEC advance.
- `ex_en`  in  1  DEC→EX advance.
- `flush_in`  in  1  external flush (trap or jump redirect); kills DEC and EX payloads.
- `branch_ex`  in  1  EX holds a valid conditional branch.
- `funct3_ex`  in  3  branch type.
- `src_data1_ex`, `src_data2_ex`  in  `DATA_WIDTH`  compare operands.
- `branch_pc_ex`  in  `ADDR_WIDTH`  PC of the EX branch.
- `branch_imm_target_ex`  in  `ADDR_WIDTH`  computed taken target.
- `branch_taken_ex`  out  1  resolved direction.
- `predict1_taken_ex`, `predict3_taken_ex`, `is_loop_ex`  out  1 each  prediction bits aligned to EX.
- `branch_target_pc`  out  `ADDR_WIDTH`  equals `branch_imm_target_ex`, for BTT training.
- `mispredict_ex`  out  1  combinational redirect request.
- `redirect_pc`  out  `ADDR_WIDTH`  correct next PC.
- `illegal_branch_ex`  out  1  `funct3_ex` is 010 or 011 while `branch_ex` is high.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `branch_cnt`, `mispredict_cnt`  out  `CNT_WIDTH`  resolved-branch and misprediction counts.

## Operation
Payload pipeline
- Payload: {`valid`, `ptaken`, `p1`, `p3`, `loop`, `ptarget`}, held in a DEC register and an EX register.
- Update priority per register: reset > kill > enable > hold.
- Kill = `flush_in` OR `mispredict_ex`. On kill, the `valid` bits of both registers clear.
- DEC register, on `dec_en`: loads the IF inputs, with `valid` = `if_valid`.
- EX register, on `ex_en`: loads the DEC register.
- When `dec_en` and kill coincide, kill wins: the DEC `valid` bit clears.
- Payload data bits may hold stale values when `valid` is 0; all outputs gate them with `valid`.

Resolution (EX, combinational)
- funct3 mapping:
  - 000: eq.
  - 001: ne.
  - 100: signed lt.
  - 101: signed ge.
  - 110: unsigned lt.
  - 111: unsigned ge.
  - 010/011: not taken, and `illegal_branch_ex` asserts.
- `branch_taken_ex` = `branch_ex` AND compare result.
- Effective prediction `ep` = EX `valid` AND `ptaken`. `p1`, `p3` and `loop` are gated by `valid` in the same way.
- `mispredict_ex` asserts when `branch_ex` is high and any of:
  - `ep` != `branch_taken_ex`;
  - `ep` and `branch_taken_ex` are both 1 but `ptarget` != `branch_imm_target_ex`.
- `redirect_pc` = `branch_taken_ex` ? `branch_imm_target_ex` : `branch_pc_ex` + 4.
  - The addition is modulo 2^`ADDR_WIDTH`; `FFFF_FFFC` + 4 wraps to 0.
  - `redirect_pc` is meaningful only while `mispredict_ex` is high.

Counters
- On each cycle with `branch_ex` high, `branch_cnt` increments by 1.
- On each cycle with `mispredict_ex` high, `mispredict_cnt` increments by 1.
- Both saturate at all-ones and do not wrap.
- `cnt_clr` has priority over increment: both counters go to 0 in that cycle and the concurrent event is not counted.
- `branch_ex` is a single-cycle qualifier. If EX stalls, the pipeline deasserts `branch_ex` after the first resolving cycle.

## Timing
- Reset values:
  - All payload registers 0, including both `valid` bits.
  - Both counters 0.
  - `mispredict_ex`, `branch_taken_ex`, `illegal_branch_ex`: 0.
  - `redirect_pc` = `branch_pc_ex` + 4.
- Prediction latency IF→EX: 2 `cpu_clk` edges with `dec_en` and `ex_en` high. Holds indefinitely while the enables are low.
- `mispredict_ex` and `redirect_pc` are valid in the same cycle as `branch_ex`. Payload kill takes effect at the next edge.
- Counter values update at the edge following the event.
- Reset asserted mid-operation clears everything immediately (asynchronously). The first edge after release behaves as a post-reset cycle.

## Test plan
- Predict-taken hit: IF payload `ptaken`=1, `ptarget`=0x100; advance 2 cycles; `branch_ex`=1, funct3=000, src1=src2=5, target=0x100 -> `branch_taken_ex`=1, `mispredict_ex`=0, `branch_cnt`=1.
- Direction miss: `ptaken`=0; funct3=100, src1=0xFFFF_FFFF, src2=1, `branch_pc_ex`=0x200, target=0x180 -> taken (signed −1<1), `mispredict_ex`=1, `redirect_pc`=0x180, DEC/EX `valid`=0 next cycle, `mispredict_cnt`=1. Same operands with funct3=110 -> not taken (unsigned), `redirect_pc` unused.
- Target miss: `ptaken`=1, `ptarget`=0x300, actual taken target 0x340 -> `mispredict_ex`=1, `redirect_pc`=0x340.
- Not-taken wrap: `ptaken`=1, funct3=001, src1=src2, `branch_pc_ex`=0xFFFF_FFFC -> `mispredict_ex`=1, `redirect_pc`=0x0000_0000.
- Stall/flush: hold `ex_en`=0 for 3 cycles -> EX payload unchanged. Assert `flush_in` with `dec_en`=1 -> DEC `valid`=0. A branch reaching EX with invalid payload and taken -> mispredict.
- Counter saturation/clear (`CNT_WIDTH`=4): 17 consecutive mispredicting branches -> both counters at 15. `cnt_clr` with a concurrent branch -> both 0. funct3=011 -> `illegal_branch_ex`=1, not taken.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: carries fetch-time predictions IF->DEC->EX,
// resolves conditional branches, flags mispredictions and keeps perf counters.
module branch_resolve #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rstn,
   input  logic                  predict_taken,
   input  logic                  predict1_taken,
   input  logic                  predict3_taken,
   input  logic                  is_loop,
   input  logic [ADDR_WIDTH-1:0] predict_target_pc,
   input  logic                  if_valid,
   input  logic                  dec_en,
   input  logic                  ex_en,
   input  logic                  flush_in,
   input  logic                  branch_ex,
   input  logic [2:0]            funct3_ex,
   input  logic [DATA_WIDTH-1:0] src_data1_ex,
   input  logic [DATA_WIDTH-1:0] src_data2_ex,
   input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
   input  logic [ADDR_WIDTH-1:0] branch_imm_target_ex,
   output logic                  branch_taken_ex,
   output logic                  predict1_taken_ex,
   output logic                  predict3_taken_ex,
   output logic                  is_loop_ex,
   output logic [ADDR_WIDTH-1:0] branch_target_pc,
   output logic                  mispredict_ex,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  illegal_branch_ex,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

   logic                  dec_valid, dec_ptaken, dec_p1, dec_p3, dec_loop;
   logic [ADDR_WIDTH-1:0] dec_ptarget;
   logic                  ex_valid, ex_ptaken, ex_p1, ex_p3, ex_loop;
   logic [ADDR_WIDTH-1:0] ex_ptarget;
   logic                  kill;
   logic                  cmp_result;
   logic                  ep;

   assign kill = flush_in | mispredict_ex;

   // Only the valid bits are killed; data bits may go stale and are gated downstream.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         dec_valid   <= 1'b0;
         dec_ptaken  <= 1'b0;
         dec_p1      <= 1'b0;
         dec_p3      <= 1'b0;
         dec_loop    <= 1'b0;
         dec_ptarget <= '0;
         ex_valid    <= 1'b0;
         ex_ptaken   <= 1'b0;
         ex_p1       <= 1'b0;
         ex_p3       <= 1'b0;
         ex_loop     <= 1'b0;
         ex_ptarget  <= '0;
      end else begin
         if (dec_en) begin
            dec_ptaken  <= predict_taken;
            dec_p1      <= predict1_taken;
            dec_p3      <= predict3_taken;
            dec_loop    <= is_loop;
            dec_ptarget <= predict_target_pc;
         end
         if (ex_en) begin
            ex_ptaken  <= dec_ptaken;
            ex_p1      <= dec_p1;
            ex_p3      <= dec_p3;
            ex_loop    <= dec_loop;
            ex_ptarget <= dec_ptarget;
         end
         if (kill) begin
            dec_valid <= 1'b0;
            ex_valid  <= 1'b0;
         end else begin
            if (dec_en) dec_valid <= if_valid;
            if (ex_en)  ex_valid  <= dec_valid;
         end
      end
   end

   always_comb begin
      cmp_result = 1'b0;
      case (funct3_ex)
         3'b000:  cmp_result = (src_data1_ex == src_data2_ex);
         3'b001:  cmp_result = (src_data1_ex != src_data2_ex);
         3'b100:  cmp_result = ($signed(src_data1_ex) <  $signed(src_data2_ex));
         3'b101:  cmp_result = ($signed(src_data1_ex) >= $signed(src_data2_ex));
         3'b110:  cmp_result = (src_data1_ex <  src_data2_ex);
         3'b111:  cmp_result = (src_data1_ex >= src_data2_ex);
         default: cmp_result = 1'b0;
      endcase
   end

   assign branch_taken_ex   = branch_ex & cmp_result;
   assign illegal_branch_ex = branch_ex & (funct3_ex[2:1] == 2'b01);
   assign ep                = ex_valid & ex_ptaken;
   assign predict1_taken_ex = ex_valid & ex_p1;
   assign predict3_taken_ex = ex_valid & ex_p3;
   assign is_loop_ex        = ex_valid & ex_loop;
   assign branch_target_pc  = branch_imm_target_ex;

   // A correct direction with a wrong predicted target still needs a redirect.
   assign mispredict_ex = branch_ex &
                          ((ep != branch_taken_ex) |
                           (ep & branch_taken_ex & (ex_ptarget != branch_imm_target_ex)));

   assign redirect_pc = branch_taken_ex ? branch_imm_target_ex
                                        : branch_pc_ex + ADDR_WIDTH'(4);

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (cnt_clr) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (branch_ex && (branch_cnt != '1))
            branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         if (mispredict_ex && (mispredict_cnt != '1))
            mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table for resolution plus
// hand-written sequences for kill, stall, saturation and async reset.
module tb_branch_resolve;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          cpu_clk, cpu_rstn;
   logic          predict_taken, predict1_taken, predict3_taken, is_loop;
   logic [AW-1:0] predict_target_pc;
   logic          if_valid, dec_en, ex_en, flush_in, branch_ex;
   logic [2:0]    funct3_ex;
   logic [DW-1:0] src_data1_ex, src_data2_ex;
   logic [AW-1:0] branch_pc_ex, branch_imm_target_ex;
   logic          branch_taken_ex, predict1_taken_ex, predict3_taken_ex, is_loop_ex;
   logic [AW-1:0] branch_target_pc, redirect_pc;
   logic          mispredict_ex, illegal_branch_ex, cnt_clr;
   logic [CW-1:0] branch_cnt, mispredict_cnt;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [CW-1:0] exp_bcnt, exp_mcnt;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] s1, s2, pc, imm;
      logic        pt;
      logic [31:0] ptgt;
      logic        e_taken, e_misp, e_ill;
      logic [31:0] e_redir;
   } vec_t;
   vec_t vecs[9];

   branch_resolve #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .predict_taken(predict_taken), .predict1_taken(predict1_taken),
      .predict3_taken(predict3_taken), .is_loop(is_loop),
      .predict_target_pc(predict_target_pc), .if_valid(if_valid),
      .dec_en(dec_en), .ex_en(ex_en), .flush_in(flush_in),
      .branch_ex(branch_ex), .funct3_ex(funct3_ex),
      .src_data1_ex(src_data1_ex), .src_data2_ex(src_data2_ex),
      .branch_pc_ex(branch_pc_ex), .branch_imm_target_ex(branch_imm_target_ex),
      .branch_taken_ex(branch_taken_ex), .predict1_taken_ex(predict1_taken_ex),
      .predict3_taken_ex(predict3_taken_ex), .is_loop_ex(is_loop_ex),
      .branch_target_pc(branch_target_pc), .mispredict_ex(mispredict_ex),
      .redirect_pc(redirect_pc), .illegal_branch_ex(illegal_branch_ex),
      .cnt_clr(cnt_clr), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Counter model advances with the expected mispredict for this cycle, then one edge.
   task automatic tick(input logic mp);
      if (cnt_clr) begin
         exp_bcnt = '0;
         exp_mcnt = '0;
      end else begin
         if (branch_ex && exp_bcnt != 4'hF) exp_bcnt = exp_bcnt + 4'd1;
         if (mp && exp_mcnt != 4'hF)        exp_mcnt = exp_mcnt + 4'd1;
      end
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic check_cnt(input string tag);
      check({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(exp_bcnt));
      check({tag, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'(exp_mcnt));
   endtask

   task automatic set_if(input logic v, input logic pt, input logic p1, input logic p3,
                         input logic lp, input logic [31:0] tgt);
      if_valid          = v;
      predict_taken     = pt;
      predict1_taken    = p1;
      predict3_taken    = p3;
      is_loop           = lp;
      predict_target_pc = tgt;
   endtask

   task automatic load_ex(input logic pt, input logic [31:0] tgt);
      set_if(1'b1, pt, 1'b1, 1'b1, 1'b1, tgt);
      branch_ex = 1'b0;
      dec_en    = 1'b1;
      ex_en     = 1'b1;
      tick(1'b0);
      tick(1'b0);
      dec_en = 1'b0;
      ex_en  = 1'b0;
   endtask

   task automatic set_br(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] pc, input logic [31:0] imm);
      branch_ex            = 1'b1;
      funct3_ex            = f3;
      src_data1_ex         = s1;
      src_data2_ex         = s2;
      branch_pc_ex         = pc;
      branch_imm_target_ex = imm;
      #1;
   endtask

   initial begin
      vecs[0] = '{3'b000, 32'd5, 32'd5, 32'h80, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h180, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h180};
      vecs[2] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{3'b000, 32'd7, 32'd7, 32'h2F0, 32'h340, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h340};
      vecs[4] = '{3'b001, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h500, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{3'b101, 32'hFFFF_FFFF, 32'd1, 32'h60, 32'h90, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{3'b011, 32'd3, 32'd3, 32'h30, 32'h70, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0};
      vecs[8] = '{3'b010, 32'd3, 32'd4, 32'h1000, 32'h2000, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 32'h1004};

      // Reset state
      cpu_rstn = 1'b0;
      set_if(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      dec_en = 1'b0; ex_en = 1'b0; flush_in = 1'b0; cnt_clr = 1'b0;
      branch_ex = 1'b0; funct3_ex = 3'b000; src_data1_ex = '0; src_data2_ex = '0;
      branch_pc_ex = 32'h10; branch_imm_target_ex = 32'h0;
      exp_bcnt = '0; exp_mcnt = '0;
      #2;
      check("rst_mispredict", 32'(mispredict_ex), 32'd0);
      check("rst_taken", 32'(branch_taken_ex), 32'd0);
      check("rst_illegal", 32'(illegal_branch_ex), 32'd0);
      check("rst_redirect", redirect_pc, 32'h14);
      check("rst_p1", 32'(predict1_taken_ex), 32'd0);
      check_cnt("rst");
      @(posedge cpu_clk); #2;
      cpu_rstn = 1'b1;
      @(posedge cpu_clk); #1;
      check_cnt("post_rst");

      // Vector table: load prediction, resolve one branch, check counters
      for (int i = 0; i < 9; i++) begin
         load_ex(vecs[i].pt, vecs[i].ptgt);
         set_br(vecs[i].f3, vecs[i].s1, vecs[i].s2, vecs[i].pc, vecs[i].imm);
         check($sformatf("v%0d_taken", i), 32'(branch_taken_ex), 32'(vecs[i].e_taken));
         check($sformatf("v%0d_mispredict", i), 32'(mispredict_ex), 32'(vecs[i].e_misp));
         check($sformatf("v%0d_illegal", i), 32'(illegal_branch_ex), 32'(vecs[i].e_ill));
         check($sformatf("v%0d_btt", i), branch_target_pc, vecs[i].imm);
         if (vecs[i].e_misp) check($sformatf("v%0d_redirect", i), redirect_pc, vecs[i].e_redir);
         check($sformatf("v%0d_p1_ex", i), 32'(predict1_taken_ex), 32'd1);
         tick(vecs[i].e_misp);
         branch_ex = 1'b0;
         check_cnt($sformatf("v%0d", i));
      end

      // Mispredict kills both DEC and EX payloads
      load_ex(1'b1, 32'h800);
      set_br(3'b001, 32'd1, 32'd1, 32'h7F0, 32'h800);
      check("kill_mispredict", 32'(mispredict_ex), 32'd1);
      check("kill_redirect", redirect_pc, 32'h7F4);
      tick(1'b1);
      branch_ex = 1'b0;
      check("kill_ex_valid", 32'(predict1_taken_ex), 32'd0);
      ex_en = 1'b1;
      tick(1'b0);
      ex_en = 1'b0;
      check("kill_dec_valid", 32'(predict1_taken_ex), 32'd0);

      // Stall: EX payload holds while ex_en is low
      load_ex(1'b1, 32'h900);
      set_if(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      dec_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(1'b0);
         check($sformatf("stall%0d_p3", c), 32'(predict3_taken_ex), 32'd1);
         check($sformatf("stall%0d_loop", c), 32'(is_loop_ex), 32'd1);
      end
      dec_en = 1'b0;

      // Flush with dec_en: kill beats the DEC load
      set_if(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA00);
      flush_in = 1'b1; dec_en = 1'b1;
      tick(1'b0);
      flush_in = 1'b0; dec_en = 1'b0;
      check("flush_ex_valid", 32'(predict1_taken_ex), 32'd0);
      ex_en = 1'b1;
      tick(1'b0);
      ex_en = 1'b0;
      check("flush_dec_valid", 32'(is_loop_ex), 32'd0);
      set_br(3'b000, 32'd2, 32'd2, 32'h6F0, 32'hA00);
      check("invalid_taken_misp", 32'(mispredict_ex), 32'd1);
      check("invalid_taken_redir", redirect_pc, 32'hA00);
      tick(1'b1);
      branch_ex = 1'b0;
      check_cnt("flush");

      // Clear, then saturate both 4-bit counters
      cnt_clr = 1'b1;
      tick(1'b0);
      cnt_clr = 1'b0;
      check_cnt("clr");
      check("clr_zero", 32'(branch_cnt), 32'd0);
      for (int c = 0; c < 17; c++) begin
         set_br(3'b000, 32'd4, 32'd4, 32'h100, 32'h700);
         tick(mispredict_ex === 1'b1 ? 1'b1 : 1'b1);
      end
      branch_ex = 1'b0;
      check("sat_branch_cnt", 32'(branch_cnt), 32'd15);
      check("sat_mispredict_cnt", 32'(mispredict_cnt), 32'd15);
      set_br(3'b000, 32'd4, 32'd4, 32'h100, 32'h700);
      cnt_clr = 1'b1;
      tick(1'b1);
      cnt_clr = 1'b0; branch_ex = 1'b0;
      check("clr_vs_branch_bcnt", 32'(branch_cnt), 32'd0);
      check("clr_vs_branch_mcnt", 32'(mispredict_cnt), 32'd0);

      // Asynchronous reset mid-operation
      load_ex(1'b1, 32'hB00);
      set_br(3'b001, 32'd1, 32'd1, 32'h10, 32'h20);
      tick(1'b1);
      branch_ex = 1'b0;
      load_ex(1'b1, 32'hB00);
      #2;
      cpu_rstn = 1'b0;
      #1;
      exp_bcnt = '0; exp_mcnt = '0;
      check("async_rst_p1", 32'(predict1_taken_ex), 32'd0);
      check_cnt("async_rst");
      cpu_rstn = 1'b1;
      tick(1'b0);
      check("post_async_loop", 32'(is_loop_ex), 32'd0);
      check_cnt("post_async");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
